// File: rtl/splitter_seq_pkg.sv
// Shared types for the splitter job sequencer: FSM states and the default-width job descriptor.
package splitter_seq_pkg;

    localparam int SEQ_PCKT_W   = 32;
    localparam int SEQ_REPEAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ERROR = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_PCKT_W-1:0]   size;
        logic [SEQ_REPEAT_W-1:0] rpt;
    } seq_desc_t;

endpackage

// File: rtl/splitter_seq_desc_fifo.sv
// Job descriptor queue: synchronous FIFO with flush, occupancy count, full and empty.
// Push is ignored when full and pop when empty; flush wins over a same-cycle push or pop.
module splitter_seq_desc_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_dat,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_dat   = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/splitter_job_sequencer.sv
// Runs queued {size, repeat} jobs on the AXI-Stream splitter; op_start two cycles after an idle accept.
// Descriptor ready is !full; optional run watchdog under SPLITTER_SEQ_TIMEOUT_EN.
module splitter_job_sequencer
    import splitter_seq_pkg::*;
#(
    parameter int PCKT_WIDTH     = 32,
    parameter int REPEAT_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PCKT_WIDTH-1:0]           s_job_size,
    input  logic [REPEAT_WIDTH-1:0]         s_job_repeat,
    input  logic                            s_job_valid,
    output logic                            s_job_ready,
    input  logic                            abort,
    input  logic                            err_clear,
    output logic                            op_start,
    output logic [PCKT_WIDTH-1:0]           op_packet_size,
    output logic                            op_external_error,
    input  logic                            op_busy,
    input  logic                            op_complete,
    input  logic                            op_error,
    output logic                            seq_busy,
    output logic                            job_done,
    output logic                            job_error,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] jobs_pending
);

    localparam int DW = PCKT_WIDTH + REPEAT_WIDTH;

    typedef struct packed {
        logic [PCKT_WIDTH-1:0]   size;
        logic [REPEAT_WIDTH-1:0] rpt;
    } desc_t;

    seq_state_t            r_state;
    logic                  r_op_start;
    logic [PCKT_WIDTH-1:0] r_size;
    logic                  r_ext_err;
    logic                  r_job_done;
    logic                  r_job_error;
    logic [REPEAT_WIDTH-1:0] r_remaining;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic [DW-1:0]         w_fifo_dat;
    desc_t                 w_head;
    logic                  w_timeout;

    assign w_head = desc_t'(w_fifo_dat);
    assign w_pop  = (r_state == IDLE) && !w_empty && !abort;

    splitter_seq_desc_fifo #(
        .DATA_W (DW),
        .DEPTH  (FIFO_DEPTH)
    ) u_desc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_push  (s_job_valid),
        .i_dat   ({s_job_size, s_job_repeat}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_count (jobs_pending),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef SPLITTER_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (r_state == START) begin
            r_run_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_run_cnt <= r_run_cnt + TW'(1);
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_run_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: WAIT only leaves on complete, error or abort.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // op_start is registered on entry to START when the splitter looked idle, else raised once op_busy drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op_start  <= 1'b0;
            r_size      <= '0;
            r_ext_err   <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_error <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_op_start  <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_error <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_remaining <= '0;
                r_ext_err   <= (r_state == START) || (r_state == WAIT);
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ext_err <= 1'b0;
                        if (!w_empty) begin
                            r_size      <= w_head.size;
                            r_remaining <= w_head.rpt;
                            if (w_head.rpt == '0) begin
                                r_job_done <= 1'b1;
                            end else begin
                                r_state    <= START;
                                r_op_start <= !op_busy;
                            end
                        end
                    end
                    START: begin
                        if (r_op_start) begin
                            r_state <= WAIT;
                        end else if (!op_busy) begin
                            r_op_start <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (op_error || w_timeout) begin
                            r_state     <= ERROR;
                            r_job_error <= 1'b1;
                            r_ext_err   <= 1'b1;
                            r_remaining <= '0;
                        end else if (op_complete) begin
                            if (r_remaining <= REPEAT_WIDTH'(1)) begin
                                r_remaining <= '0;
                                r_job_done  <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_remaining <= r_remaining - REPEAT_WIDTH'(1);
                                r_state     <= START;
                                r_op_start  <= !op_busy;
                            end
                        end
                    end
                    ERROR: begin
                        if (err_clear) begin
                            r_state   <= IDLE;
                            r_ext_err <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign s_job_ready       = !w_full;
    assign op_start          = r_op_start;
    assign op_packet_size    = r_size;
    assign op_external_error = r_ext_err;
    assign job_done          = r_job_done;
    assign job_error         = r_job_error;
    assign seq_busy          = (r_state != IDLE) || !w_empty;

endmodule
